// File: rtl/counter_wrap.sv
// Modulo up/down counter with wrap or saturate behaviour, a one-cycle wrap
// pulse and a saturating count of wrap events since reset.
module counter_wrap #(
  parameter int WIDTH  = 8,
  parameter int MODULO = 256,
  parameter int LOOP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              sat,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              loop,
  output logic              at_end,
  output logic [LOOP_W-1:0] loop_cnt
);

  generate
    if (WIDTH < 1 || LOOP_W < 1) begin : g_bad_width
      $error("counter_wrap: WIDTH and LOOP_W must be at least 1");
    end
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
      $error("counter_wrap: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0]  MAX      = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
  localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);
  localparam logic [LOOP_W-1:0] LOOP_TOP = '1;

  logic [WIDTH-1:0] count_nxt;
  logic             wrap;

  assign at_end = dir ? (count == MAX) : (count == '0);

  // Terminal values are compared explicitly so count never leaves 0..MAX,
  // even when MODULO is not a power of two.
  always_comb begin
    count_nxt = count;
    wrap      = 1'b0;
    if (load) begin
      count_nxt = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (dir) begin
        if (count != MAX) begin
          count_nxt = count + ONE;
        end else if (!sat) begin
          count_nxt = '0;
          wrap      = 1'b1;
        end
      end else begin
        if (count != '0) begin
          count_nxt = count - ONE;
        end else if (!sat) begin
          count_nxt = MAX;
          wrap      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      loop     <= 1'b0;
      loop_cnt <= '0;
    end else begin
      count <= count_nxt;
      loop  <= wrap;
      if (wrap && loop_cnt != LOOP_TOP) begin
        loop_cnt <= loop_cnt + LOOP_ONE;
      end
    end
  end

endmodule
